exec_trace_buffer: RTL and testbench
====================================

# exec_trace_buffer

Capture FIFO sitting directly downstream of the RV32I processor core. Samples the core's `PC_out` and `ALU_Output` every clock, records one (PC, ALU result) pair for each new instruction, and drains them through a valid/ready port to a debug or trace consumer. Overflow is counted rather than stalling the core, which has no backpressure input.

## Interface
- `DEPTH`, 16: number of trace entries; power of two, ≥ 2.
- `OVF_W`, 16: width of the saturating overflow counter.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `pc_in` in 32: connected to the core's `PC_out`.
- `alu_in` in 32: connected to the core's `ALU_Output`.
- `capture_en` in 1: enables capture; low means no entries are written.
- `trace_valid` out 1: head entry available.
- `trace_ready` in 1: consumer accepts the head entry.
- `trace_pc` out 32: PC of the head entry.
- `trace_alu` out 32: ALU result of the head entry.
- `count` out $clog2(DEPTH)+1: entries held, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow_cnt` out OVF_W: captures dropped because the FIFO was full; saturates at all-ones.

## Operation
**State registers**
- `last_pc` (32), `primed` (1), write/read pointers (log2 DEPTH each), `count`, `overflow_cnt`, and storage of DEPTH × 64 bits.
- Storage is not reset. All other registers are reset.

**Capture condition**, evaluated at each rising edge:
- `cap = capture_en && (!primed || pc_in != last_pc)`.
- When `capture_en` is high, `last_pc` is updated to `pc_in` and `primed` is set to 1.
- When `capture_en` is low, `primed` is cleared. The first sample after re-enable is always captured, even if the PC is unchanged.
- A repeated PC, for example a `jal x0,0` halt loop, produces exactly one entry.

**Push/pop**
- `pop = trace_valid && trace_ready`.
- `push = cap && (!full || pop)`.
- If `cap && full && !pop`, the sample is dropped and `overflow_cnt` increments, saturating.
- `count` next value: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Pointers wrap modulo DEPTH.

**Output port**
- Show-ahead. `trace_pc`/`trace_alu` equal the entry at the read pointer when `!empty`, and are forced to 0 when empty.
- `trace_valid = !empty`.
- Valid/ready rules: once `trace_valid` is high, the head data holds stable until popped. `trace_valid` never drops without a pop. The consumer may hold `trace_ready` high continuously.

**Reset**
- Asserting `reset` at any time, including mid-drain, empties the FIFO immediately (asynchronously).
- Outputs while reset is asserted: `trace_valid`=0, `trace_pc`=0, `trace_alu`=0, `count`=0, `full`=0, `empty`=1, `overflow_cnt`=0.
- Internal state on reset: `primed`=0, `last_pc`=0.
- The first edge after release with `capture_en`=1 captures unconditionally.

## Timing
- Capture to visibility: 1 cycle. A sample at edge N appears on `trace_valid`/`trace_pc` immediately after edge N.
- Pop takes effect at the edge where `trace_valid && trace_ready`. The next entry, or empty, is visible after that edge.
- Full and popping in the same cycle: push accepted, `count` stays DEPTH, no overflow.
- Empty with a push: no same-cycle bypass. `trace_valid` rises after the edge.
- `full`, `empty`, and `count` are derived from registered state only. There is no combinational path from `pc_in`/`alu_in` to any output.
- Throughput: one capture and one drain per cycle sustained.

## Test plan
- **Reset values:** hold `reset`=1 for 2 cycles → all outputs at their reset values, `empty`=1, `overflow_cnt`=0.
- **Ordered capture:** `capture_en`=1, drive PC sequence 0x00,0x04,0x04,0x08 with ALU 0x11,0x22,0x33,0x44 and `trace_ready`=0 → `count`=3. Draining yields (0x00,0x11), (0x04,0x22), (0x08,0x44), then `empty`.
- **Overflow:** DEPTH=16, `trace_ready`=0, 20 distinct PCs 0x00..0x4C → `full`=1, `count`=16, `overflow_cnt`=4. Drain returns PCs 0x00..0x3C in order.
- **Full with simultaneous pop:** FIFO full, `trace_ready`=1, new PC 0x100 → `count` stays 16, `overflow_cnt` unchanged, and 0x100 is the last entry drained.
- **Re-enable:** PC held at 0x20, toggle `capture_en` 1→0→1 → two entries with PC 0x20, one per enable.
- **Mid-drain reset:** with 5 entries and `trace_ready`=1, pulse `reset` asynchronously between edges → `trace_valid` drops without waiting for a clock edge. After release, the next capture of PC 0x40 is the sole entry.

Source files
------------

// File: rtl/exec_trace_buffer.sv
// Trace capture FIFO for the RV32I core.
// Records one (PC, ALU result) pair per new instruction and drains the pairs
// through a show-ahead valid/ready port. The core cannot be stalled, so
// captures that arrive while the FIFO is full are dropped and counted.
module exec_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int OVF_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              pc_in,
   input  logic [31:0]              alu_in,
   input  logic                     capture_en,
   output logic                     trace_valid,
   input  logic                     trace_ready,
   output logic [31:0]              trace_pc,
   output logic [31:0]              trace_alu,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic [OVF_W-1:0]         overflow_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [OVF_W-1:0] OVF_ONE  = OVF_W'(1);

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
      return (&v) ? v : v + OVF_ONE;
   endfunction

   logic [31:0]      last_pc_q, last_pc_d;
   logic             primed_q, primed_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [OVF_W-1:0] ovf_q, ovf_d;
   logic [63:0]      mem [DEPTH];

   logic cap;
   logic pop;
   logic push;
   logic drop;

   // Status and show-ahead head data come from registered state only.
   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == FULL_CNT);
      count       = count_q;
      trace_valid = !empty;
      trace_pc    = '0;
      trace_alu   = '0;
      if (!empty) begin
         trace_pc  = mem[rd_ptr_q][63:32];
         trace_alu = mem[rd_ptr_q][31:0];
      end
      overflow_cnt = ovf_q;
   end

   // Capture decision, push/pop arbitration and next-state computation.
   always_comb begin
      cap  = capture_en && (!primed_q || (pc_in != last_pc_q));
      pop  = trace_valid && trace_ready;
      push = cap && (!full || pop);
      drop = cap && full && !pop;

      // Losing capture_en forgets the last PC so the first sample after
      // re-enable is recorded even when the PC has not moved.
      last_pc_d = capture_en ? pc_in : last_pc_q;
      primed_d  = capture_en;

      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      ovf_d = drop ? sat_inc(ovf_q) : ovf_q;
   end

   // Control state; asynchronous reset empties the FIFO immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_pc_q <= '0;
         primed_q  <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= '0;
      end else begin
         last_pc_q <= last_pc_d;
         primed_q  <= primed_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   // Entry storage; contents are only meaningful below the count, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {pc_in, alu_in};
      end
   end

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Bench for exec_trace_buffer: directed capture sequences feed a queue of
// expected entries; a negedge monitor checks every entry the DUT hands over.
module tb_exec_trace_buffer;

   localparam int DEPTH = 16;
   localparam int OVF_W = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic [31:0] alu_in;
   logic        capture_en;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [31:0] trace_alu;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic [15:0] overflow_cnt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] alu;
   } ent_t;

   ent_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   exec_trace_buffer #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_in        (pc_in),
      .alu_in       (alu_in),
      .capture_en   (capture_en),
      .trace_valid  (trace_valid),
      .trace_ready  (trace_ready),
      .trace_pc     (trace_pc),
      .trace_alu    (trace_alu),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow_cnt (overflow_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: every handshake the DUT completes must match the queue head.
   always @(negedge clk) begin : monitor
      ent_t e;
      if (!reset && trace_valid && trace_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_entry: got pc 0x%08h alu 0x%08h expected none", trace_pc, trace_alu);
         end else begin
            e = exp_q.pop_front();
            check("pop_pc", trace_pc, e.pc);
            check("pop_alu", trace_alu, e.alu);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one sample for the next edge; queue it if it must be stored.
   task automatic cap(input logic [31:0] pc, input logic [31:0] alu, input bit stored);
      ent_t e;
      pc_in      = pc;
      alu_in     = alu;
      capture_en = 1'b1;
      if (stored) begin
         e.pc  = pc;
         e.alu = alu;
         exp_q.push_back(e);
      end
      step();
   endtask

   task automatic drain(input string name);
      trace_ready = 1'b1;
      for (int i = 0; i < 64 && !empty; i++) step();
      check({name, "_empty"}, {31'd0, empty}, 32'd1);
      check({name, "_left"}, 32'(exp_q.size()), 32'd0);
      check({name, "_pc_zero"}, trace_pc, 32'd0);
      trace_ready = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      reset       = 1'b1;
      capture_en  = 1'b0;
      trace_ready = 1'b0;
      pc_in       = '0;
      alu_in      = '0;

      // Reset values
      step();
      step();
      check("rst_valid", {31'd0, trace_valid}, 32'd0);
      check("rst_pc", trace_pc, 32'd0);
      check("rst_alu", trace_alu, 32'd0);
      check("rst_count", {27'd0, count}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
      reset = 1'b0;

      // Ordered capture, repeated PC suppressed
      cap(32'h00, 32'h11, 1'b1);
      check("first_visible", trace_pc, 32'h00);
      check("first_valid", {31'd0, trace_valid}, 32'd1);
      cap(32'h04, 32'h22, 1'b1);
      cap(32'h04, 32'h33, 1'b0);
      cap(32'h08, 32'h44, 1'b1);
      capture_en = 1'b0;
      check("ord_count", {27'd0, count}, 32'd3);
      drain("ord");

      // Overflow: 20 distinct PCs, last 4 dropped
      for (int i = 0; i < 20; i++) cap(32'(i * 4), 32'h1000 + 32'(i), i < 16);
      capture_en = 1'b0;
      check("ovf_full", {31'd0, full}, 32'd1);
      check("ovf_count", {27'd0, count}, 32'd16);
      check("ovf_cnt", {16'd0, overflow_cnt}, 32'd4);
      drain("ovf");

      // Full with simultaneous pop: push accepted, no overflow
      for (int i = 0; i < 16; i++) cap(32'h200 + 32'(i * 4), 32'h2000 + 32'(i), 1'b1);
      check("fp_full", {31'd0, full}, 32'd1);
      trace_ready = 1'b1;
      cap(32'h100, 32'hABC, 1'b1);
      capture_en = 1'b0;
      check("fp_count", {27'd0, count}, 32'd16);
      check("fp_ovf", {16'd0, overflow_cnt}, 32'd4);
      drain("fp");

      // Re-enable with a held PC gives one entry per enable
      cap(32'h20, 32'h1, 1'b1);
      cap(32'h20, 32'h2, 1'b0);
      capture_en = 1'b0;
      step();
      cap(32'h20, 32'h3, 1'b1);
      cap(32'h20, 32'h4, 1'b0);
      capture_en = 1'b0;
      check("reen_count", {27'd0, count}, 32'd2);
      drain("reen");

      // Mid-drain asynchronous reset
      for (int i = 0; i < 5; i++) cap(32'h300 + 32'(i * 4), 32'h3000 + 32'(i), 1'b1);
      capture_en = 1'b0;
      check("mdr_count5", {27'd0, count}, 32'd5);
      trace_ready = 1'b1;
      step();
      step();
      #1;
      reset = 1'b1;
      #1;
      check("mdr_valid_async", {31'd0, trace_valid}, 32'd0);
      check("mdr_count_async", {27'd0, count}, 32'd0);
      check("mdr_ovf_async", {16'd0, overflow_cnt}, 32'd0);
      exp_q.delete();
      #1;
      reset = 1'b0;
      cap(32'h40, 32'h55, 1'b1);
      capture_en = 1'b0;
      check("mdr_count1", {27'd0, count}, 32'd1);
      check("mdr_head", trace_pc, 32'h40);
      drain("mdr");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
